jogador_automatico: RTL and testbench

Automatic player for the memory game (`circuito_exp6`). It sits on the player side of the LED/button interface. While the game shows its sequence (`mostra_leds=1`), the block captures the LED pulses into a buffer. When the show phase ends, it replays them on `botoes` with programmable press and gap timing. The team uses it for hardware self-play, and as a reusable stimulus block in game benches in place of hand-written press loops.

---
 rtl/jogador_automatico.sv | 189 ++++++++++++++++++
 tb/tb_jogador_automatico.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: captures the shown LED sequence and replays it on botoes.
// Optional macro JOGADOR_FALHA_EN corrupts the last press of round FALHA_RODADA.
module jogador_automatico #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned START_DELAY  = 10,
  parameter int unsigned PRESS_CYCLES = 10,
  parameter int unsigned GAP_CYCLES   = 10,
  parameter int unsigned FALHA_RODADA = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     habilitar,
  input  logic [3:0]               leds,
  input  logic                     mostra_leds,
  input  logic                     pronto,
  output logic [3:0]               botoes,
  output logic                     ocupado,
  output logic [$clog2(DEPTH):0]   num_jogadas,
  output logic                     erro,
  output logic [3:0]               db_estado
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
`ifdef JOGADOR_FALHA_EN
  localparam bit FalhaEn = 1'b1;
`else
  localparam bit FalhaEn = 1'b0;
`endif

  typedef enum logic [3:0] {
    StOcioso    = 4'd0,
    StAguarda   = 4'd1,
    StCaptura   = 4'd2,
    StEspera    = 4'd3,
    StPressiona = 4'd4,
    StSolta     = 4'd5,
    StFim       = 4'd6
  } estado_e;

  estado_e        state_q, state_d;
  logic [3:0]     leds_prev_q;
  logic           mostra_prev_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  rodada_q, rodada_d;
  logic [15:0]    delay_q, delay_d;
  logic           erro_q, erro_d;
  logic [3:0]     botoes_q, botoes_d;
  logic [3:0]     buf_q [DEPTH];

  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic           nova;
  logic           one_hot;
  logic           mostra_sobe;
  logic           falha;
  logic [3:0]     press;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rodada_d    = rodada_q;
    erro_d      = erro_q;
    botoes_d    = 4'b0;
    wr_en       = 1'b0;
    wr_idx      = cnt_q[IW-1:0];
    falha       = 1'b0;
    press       = 4'b0;
    nova        = (leds != 4'b0) && (leds_prev_q == 4'b0);
    one_hot     = $onehot(leds);
    mostra_sobe = mostra_leds && !mostra_prev_q;

    if (state_q == StOcioso) rodada_d = '0;

    if (pronto) begin
      state_d = StFim;
    end else if (!habilitar) begin
      state_d = StOcioso;
    end else begin
      unique case (state_q)
        StOcioso: state_d = StAguarda;
        StAguarda: begin
          if (mostra_leds) begin
            state_d = StCaptura;
            cnt_d   = '0;
            if (nova) begin
              wr_en  = 1'b1;
              wr_idx = '0;
              cnt_d  = CW'(1);
              if (!one_hot) erro_d = 1'b1;
            end
          end
        end
        StCaptura: begin
          if (nova) begin
            if (cnt_q == CW'(DEPTH)) begin
              erro_d = 1'b1;
            end else begin
              wr_en = 1'b1;
              cnt_d = cnt_q + CW'(1);
              if (!one_hot) erro_d = 1'b1;
            end
          end
          if (!mostra_leds) begin
            if (cnt_d == '0) begin
              state_d = StAguarda;
            end else begin
              state_d  = StEspera;
              rodada_d = rodada_q + CW'(1);
            end
          end
        end
        StEspera: begin
          if (mostra_sobe) begin
            state_d = StCaptura;
            cnt_d   = '0;
          end else if (delay_q == 16'(START_DELAY)) begin
            state_d = StPressiona;
            idx_d   = '0;
          end
        end
        StPressiona: begin
          if (mostra_sobe) begin
            state_d = StCaptura;
            cnt_d   = '0;
          end else if (delay_q == 16'(PRESS_CYCLES - 1)) begin
            state_d = StSolta;
          end
        end
        StSolta: begin
          if (mostra_sobe) begin
            state_d = StCaptura;
            cnt_d   = '0;
          end else if (delay_q == 16'(GAP_CYCLES - 1)) begin
            idx_d   = idx_q + CW'(1);
            state_d = (idx_q + CW'(1) == cnt_q) ? StAguarda : StPressiona;
          end
        end
        StFim: state_d = StFim;
        default: state_d = StOcioso;
      endcase
    end

    // The round counter is bumped on entry to ESPERA, so the round being replayed is rodada_q-1.
    if (state_d == StPressiona) begin
      press = buf_q[idx_d[IW-1:0]];
      falha = FalhaEn && (rodada_q - CW'(1) == CW'(FALHA_RODADA)) && (idx_d + CW'(1) == cnt_q);
      botoes_d = falha ? {press[2:0], press[3]} : press;
    end

    delay_d = (state_d != state_q) ? 16'd0 : delay_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StOcioso;
      leds_prev_q   <= 4'b0;
      mostra_prev_q <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      rodada_q      <= '0;
      delay_q       <= 16'd0;
      erro_q        <= 1'b0;
      botoes_q      <= 4'b0;
    end else begin
      state_q       <= state_d;
      leds_prev_q   <= leds;
      mostra_prev_q <= mostra_leds;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      rodada_q      <= rodada_d;
      delay_q       <= delay_d;
      erro_q        <= erro_d;
      botoes_q      <= botoes_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) buf_q[wr_idx] <= leds;
  end

  assign botoes      = botoes_q;
  assign num_jogadas = cnt_q;
  assign erro        = erro_q;
  assign db_estado   = state_q;
  assign ocupado     = state_q inside {StCaptura, StEspera, StPressiona, StSolta};

endmodule

// File: tb/tb_jogador_automatico.sv
// Self-checking bench for jogador_automatico: table rows, random rounds and corner sequences.
module tb_jogador_automatico;
  localparam int SD    = 10;
  localparam int PC    = 10;
  localparam int GC    = 10;
  localparam int PER   = PC + GC;
  localparam int DEPTH = 16;
`ifdef JOGADOR_FALHA_EN
  localparam bit FALHA = 1'b1;
`else
  localparam bit FALHA = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       habilitar;
  logic [3:0] leds;
  logic       mostra_leds;
  logic       pronto;
  logic [3:0] botoes;
  logic       ocupado;
  logic [4:0] num_jogadas;
  logic       erro;
  logic [3:0] db_estado;

  jogador_automatico dut (
    .clock       (clock),
    .reset       (reset),
    .habilitar   (habilitar),
    .leds        (leds),
    .mostra_leds (mostra_leds),
    .pronto      (pronto),
    .botoes      (botoes),
    .ocupado     (ocupado),
    .num_jogadas (num_jogadas),
    .erro        (erro),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          n;
    logic [67:0] plays;
    int          exp_n;
    int          exp_e;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0] plays_q[$];
  logic [3:0] exp_q[$];
  int         rodada_m;
  bit         erro_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] exp_bot(input int j);
    int t = j - 1 - SD;
    int i;
    logic [3:0] v;
    if (t < 0) return 4'b0;
    i = t / PER;
    if (i >= exp_q.size() || (t % PER) >= PC) return 4'b0;
    v = exp_q[i];
    if (FALHA && rodada_m == 3 && i == exp_q.size() - 1) v = {v[2:0], v[3]};
    return v;
  endfunction

  function automatic int full_len();
    return SD + exp_q.size() * PER + 1;
  endfunction

  // Shows plays_q during a show phase, then drops mostra_leds (the edge after which ESPERA starts).
  task automatic capture(input int hold_max, input int exp_n, input int exp_e);
    exp_q.delete();
    foreach (plays_q[i]) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(plays_q[i]);
        if (!$onehot(plays_q[i])) erro_m = 1'b1;
      end else begin
        erro_m = 1'b1;
      end
    end
    mostra_leds = 1'b1;
    tick();
    foreach (plays_q[i]) begin
      leds = plays_q[i];
      repeat ($urandom_range(1, hold_max)) tick();
      leds = 4'b0;
      repeat ($urandom_range(1, hold_max)) tick();
    end
    mostra_leds = 1'b0;
    tick();
    chk("num_jogadas", num_jogadas, (exp_n < 0) ? exp_q.size() : exp_n);
    chk("erro", erro, (exp_e < 0) ? erro_m : exp_e);
    chk("estado_espera", db_estado, 3);
  endtask

  task automatic replay(input int upto);
    for (int j = 1; j <= upto; j++) begin
      tick();
      chk("botoes", botoes, exp_bot(j));
      if (j == 1) chk("ocupado_replay", ocupado, 1);
    end
    if (upto == full_len()) begin
      chk("fim_estado", db_estado, 1);
      chk("fim_ocupado", ocupado, 0);
    end
    rodada_m++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{n: 3,  plays: 68'h421,                exp_n: 3,  exp_e: 0};
    tbl[1] = '{n: 1,  plays: 68'h8,                  exp_n: 1,  exp_e: 0};
    tbl[2] = '{n: 2,  plays: 68'h12,                 exp_n: 2,  exp_e: 0};
    tbl[3] = '{n: 4,  plays: 68'h8421,               exp_n: 4,  exp_e: 0};
    tbl[4] = '{n: 1,  plays: 68'h3,                  exp_n: 1,  exp_e: 1};
    tbl[5] = '{n: 17, plays: 68'h1_8421_8421_8421_8421, exp_n: 16, exp_e: 1};

    rodada_m    = 0;
    erro_m      = 1'b0;
    reset       = 1'b1;
    habilitar   = 1'b0;
    leds        = 4'b0;
    mostra_leds = 1'b0;
    pronto      = 1'b0;
    #12;
    chk("rst_botoes", botoes, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_num", num_jogadas, 0);
    chk("rst_erro", erro, 0);
    chk("rst_estado", db_estado, 0);
    reset = 1'b0;
    tick();
    chk("ocioso", db_estado, 0);
    habilitar = 1'b1;
    tick();
    chk("aguarda", db_estado, 1);

    for (int r = 0; r < 6; r++) begin
      plays_q.delete();
      for (int i = 0; i < tbl[r].n; i++) plays_q.push_back(tbl[r].plays[4*i +: 4]);
      capture(1, tbl[r].exp_n, tbl[r].exp_e);
      replay(full_len());
    end

    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 5);
      plays_q.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) plays_q.push_back(4'($urandom_range(1, 15)));
        else plays_q.push_back(4'b1 << $urandom_range(0, 3));
      end
      capture(3, -1, -1);
      replay(full_len());
    end

    // New show phase during the second press aborts the replay
    plays_q = '{4'b0001, 4'b0010};
    capture(1, -1, -1);
    replay(SD + 1 + PER + 2);
    mostra_leds = 1'b1;
    tick();
    chk("abort_botoes", botoes, 0);
    chk("abort_estado", db_estado, 2);
    chk("abort_num", num_jogadas, 0);
    plays_q = '{4'b0100};
    capture(1, -1, -1);
    replay(full_len());

    // Game over mid-press parks in FIM until habilitar drops
    plays_q = '{4'b0001};
    capture(1, -1, -1);
    replay(SD + 3);
    pronto = 1'b1;
    tick();
    chk("fim_botoes", botoes, 0);
    chk("fim_cod", db_estado, 6);
    pronto = 1'b0;
    repeat (3) tick();
    chk("fim_hold", db_estado, 6);
    chk("fim_hold_botoes", botoes, 0);
    habilitar = 1'b0;
    tick();
    chk("fim_sai", db_estado, 0);
    chk("fim_sai_ocupado", ocupado, 0);
    habilitar = 1'b1;
    tick();
    chk("reabilita", db_estado, 1);
    rodada_m = 0;

    // Asynchronous reset mid-press
    plays_q = '{4'b1000};
    capture(1, -1, -1);
    replay(SD + 2);
    #3;
    reset = 1'b1;
    #1;
    chk("async_botoes", botoes, 0);
    chk("async_estado", db_estado, 0);
    chk("async_erro", erro, 0);
    chk("async_num", num_jogadas, 0);
    #2;
    reset = 1'b0;
    tick();
    chk("pos_reset", db_estado, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
